// File: rtl/alu_bist_ctrl_pkg.sv
// Shared definitions for the ALU BIST controller: FSM encoding, LFSR feedback
// mask and the ALU opcode map also used by the execute-stage ALU decoder.
package alu_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StApply = 3'd1,
        StCheck = 3'd2,
        StPass  = 3'd3,
        StFail  = 3'd4
    } bist_state_e;

    // Galois right-shift feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;

    // ALU opcode map; the BIST sweeps all eight codes in index order
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;
    localparam logic [2:0] AluSrl = 3'b111;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit Galois LFSR operand generator: synchronous load of a seed, one step
// per asserted step_i, state held otherwise. Load wins over step.
module bist_lfsr32
    import alu_bist_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: load seed, advance one Galois step, or hold
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LfsrTaps : 32'h0);
        end
    end

    // State register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= 32'h0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test controller. Drives LFSR operands into the primary and
// spare ALUs while the pipeline grants them, compares the two results and zero
// flags, and reports a pass/fail verdict with a one-cycle fault pulse.
module alu_bist_ctrl
    import alu_bist_ctrl_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        idle_i,
    input  logic        inject_i,
    input  logic [31:0] res_p_i,
    input  logic        zero_p_i,
    input  logic [31:0] res_s_i,
    input  logic        zero_s_i,
    output logic        bist_sel_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [2:0]  alu_ctrl_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        fail_o,
    output logic [15:0] fail_idx_o
);

    localparam logic [15:0] LastIdx = 16'(NUM_VECTORS - 1);

    bist_state_e state_q, state_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [15:0] fail_idx_q, fail_idx_d;
    logic [31:0] res_p_q, res_p_d;
    logic [31:0] res_s_q, res_s_d;
    logic        zero_p_q, zero_p_d;
    logic        zero_s_q, zero_s_d;

    logic        lfsr_load;
    logic        lfsr_step;
    logic [31:0] lfsr_state;
    logic        mismatch;

    bist_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (LFSR_SEED),
        .state_o (lfsr_state)
    );

    // Compare registers hold the sample taken in the last granted APPLY cycle
    assign mismatch = (res_p_q != res_s_q) || (zero_p_q != zero_s_q);

    // Next-state and registered-output logic for the test sequencer
    always_comb begin
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fail_d     = fail_q;
        fail_idx_d = fail_idx_q;
        res_p_d    = res_p_q;
        res_s_d    = res_s_q;
        zero_p_d   = zero_p_q;
        zero_s_d   = zero_s_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StApply;
                    lfsr_load  = 1'b1;
                    vec_idx_d  = 16'd0;
                    fail_d     = 1'b0;
                    fail_idx_d = 16'd0;
                    busy_d     = 1'b1;
                end
            end
            StApply: begin
                // Without the grant everything holds, costing exactly one cycle
                if (idle_i) begin
                    res_p_d  = res_p_i ^ {31'b0, inject_i};
                    res_s_d  = res_s_i;
                    zero_p_d = zero_p_i;
                    zero_s_d = zero_s_i;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    state_d    = StFail;
                    fail_d     = 1'b1;
                    fail_idx_d = vec_idx_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (vec_idx_q == LastIdx) begin
                    state_d = StPass;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lfsr_step = 1'b1;
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = StApply;
                end
            end
            StPass, StFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state; reset aborts any run without a done or fault pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            vec_idx_q  <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_idx_q <= 16'd0;
            res_p_q    <= 32'h0;
            res_s_q    <= 32'h0;
            zero_p_q   <= 1'b0;
            zero_s_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_idx_q  <= vec_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
            res_p_q    <= res_p_d;
            res_s_q    <= res_s_d;
            zero_p_q   <= zero_p_d;
            zero_s_q   <= zero_s_d;
        end
    end

    // Operands come straight from flops so the ALUs see them from cycle start
    assign a_o        = lfsr_state;
    assign b_o        = bit_rev32(lfsr_state);
    assign alu_ctrl_o = vec_idx_q[2:0];

    // Operand mux follows the grant combinationally, only while applying
    assign bist_sel_o = (state_q == StApply) && idle_i;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign fail_idx_o = fail_idx_q;
    // Decoded from registers only; high during the CHECK cycle that fails
    assign fault_o    = (state_q == StCheck) && mismatch;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Scoreboard bench for alu_bist_ctrl: stimulus pushes expected done/fault
// events, a negedge monitor pops and compares them when the DUT pulses.
module tb_alu_bist_ctrl;

    localparam int unsigned NV   = 8;
    localparam logic [31:0] Seed = 32'hACE1_0001;

    typedef struct {
        int          cyc;
        logic        fail;
        logic [15:0] idx;
    } done_exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        idle_i;
    logic        inject_i;
    logic        zflip;
    logic [31:0] res_p;
    logic        zero_p;
    logic [31:0] res_s;
    logic        zero_s;
    logic        bist_sel_o;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [2:0]  alu_ctrl_o;
    logic        busy_o;
    logic        done_o;
    logic        fault_o;
    logic        fail_o;
    logic [15:0] fail_idx_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    done_exp_t exp_done[$];
    int        exp_fault[$];
    done_exp_t de;
    int        fc;

    alu_bist_ctrl #(
        .NUM_VECTORS (NV),
        .LFSR_SEED   (Seed)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .start_i    (start_i),
        .idle_i     (idle_i),
        .inject_i   (inject_i),
        .res_p_i    (res_p),
        .zero_p_i   (zero_p),
        .res_s_i    (res_s),
        .zero_s_i   (zero_s),
        .bist_sel_o (bist_sel_o),
        .a_o        (a_o),
        .b_o        (b_o),
        .alu_ctrl_o (alu_ctrl_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fault_o    (fault_o),
        .fail_o     (fail_o),
        .fail_idx_o (fail_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fault-free reference ALU shared by both result ports
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return {31'b0, $signed(a) < $signed(b)};
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    assign res_p  = alu(a_o, b_o, alu_ctrl_o);
    assign zero_p = (res_p == 32'h0);
    assign res_s  = res_p;
    assign zero_s = zero_p ^ zflip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/fault pulse must match the head of its queue
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                de = exp_done.pop_front();
                chk("done_cycle", 32'(cyc), 32'(de.cyc));
                chk("done_fail", 32'(fail_o), 32'(de.fail));
                chk("done_idx", 32'(fail_idx_o), 32'(de.idx));
            end
        end
        if (fault_o) begin
            if (exp_fault.size() == 0) begin
                chk("unexpected_fault", 32'(fault_o), 32'd0);
            end else begin
                fc = exp_fault.pop_front();
                chk("fault_cycle", 32'(cyc), 32'(fc));
            end
        end
    end

    // Called at a negedge: start_i is high for cycle sc, APPLY follows in sc+1
    task automatic do_start(output int sc);
        start_i = 1'b1;
        sc      = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic push_done(input int c, input logic f, input logic [15:0] idx);
        done_exp_t e;
        e.cyc  = c;
        e.fail = f;
        e.idx  = idx;
        exp_done.push_back(e);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_done.size() != 0 || exp_fault.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("timeout_done_q", 32'(exp_done.size()), 32'd0);
        chk("timeout_fault_q", 32'(exp_fault.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        rst_n    = 1'b1;
        start_i  = 1'b0;
        idle_i   = 1'b1;
        inject_i = 1'b0;
        zflip    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a", a_o, 32'h0);
        chk("rst_b", b_o, 32'h0);
        chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_fail", 32'(fail_o), 32'd0);
        chk("rst_idx", 32'(fail_idx_o), 32'd0);
        chk("rst_sel", 32'(bist_sel_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run with a start pulse during CHECK of vector 1
        do_start(sc);
        push_done(sc + 17, 1'b0, 16'd0);
        #1;
        chk("v0_a", a_o, 32'hACE1_0001);
        chk("v0_b", b_o, 32'h8000_8735);
        chk("v0_ctrl", 32'(alu_ctrl_o), 32'd0);
        chk("v0_busy", 32'(busy_o), 32'd1);
        chk("v0_sel", 32'(bist_sel_o), 32'd1);
        @(negedge clk);
        #1;
        chk("check_sel", 32'(bist_sel_o), 32'd0);
        chk("check_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        #1;
        chk("v1_a", a_o, 32'hD650_8003);
        chk("v1_ctrl", 32'(alu_ctrl_o), 32'd1);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("v2_a", a_o, 32'hEB08_4002);
        chk("v2_b", b_o, 32'h4002_10D7);
        chk("v2_ctrl", 32'(alu_ctrl_o), 32'd2);
        wait_empty();
        chk("pass_fail_o", 32'(fail_o), 32'd0);

        // Injection from vector 3 onward
        do_start(sc);
        push_done(sc + 9, 1'b1, 16'd3);
        exp_fault.push_back(sc + 8);
        repeat (6) @(negedge clk);
        inject_i = 1'b1;
        wait_empty();
        inject_i = 1'b0;
        #1;
        chk("sticky_fail", 32'(fail_o), 32'd1);
        chk("sticky_idx", 32'(fail_idx_o), 32'd3);
        chk("after_fail_busy", 32'(busy_o), 32'd0);

        // Zero-flag-only mismatch at vector 0; acceptance clears fail_o
        zflip = 1'b1;
        do_start(sc);
        push_done(sc + 3, 1'b1, 16'd0);
        exp_fault.push_back(sc + 2);
        #1;
        chk("restart_clear_fail", 32'(fail_o), 32'd0);
        chk("restart_clear_idx", 32'(fail_idx_o), 32'd0);
        @(negedge clk);
        zflip = 1'b0;
        wait_empty();
        chk("zero_fail_o", 32'(fail_o), 32'd1);

        // Five stall cycles during APPLY of vector 2
        do_start(sc);
        push_done(sc + 22, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        idle_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("stall_sel", 32'(bist_sel_o), 32'd0);
            chk("stall_a", a_o, 32'hEB08_4002);
            chk("stall_ctrl", 32'(alu_ctrl_o), 32'd2);
        end
        @(negedge clk);
        idle_i = 1'b1;
        wait_empty();

        // Reset at vector 4 aborts silently; a fresh run restarts from the seed
        do_start(sc);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", a_o, 32'h0);
        chk("mid_rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_fault", 32'(fault_o), 32'd0);
        chk("mid_rst_sel", 32'(bist_sel_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        do_start(sc);
        push_done(sc + 17, 1'b0, 16'd0);
        #1;
        chk("fresh_a", a_o, 32'hACE1_0001);
        chk("fresh_ctrl", 32'(alu_ctrl_o), 32'd0);
        wait_empty();

        repeat (5) @(negedge clk);
        chk("leftover_done", 32'(exp_done.size()), 32'd0);
        chk("leftover_fault", 32'(exp_fault.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
